// File: rtl/seven_segment_to_binary_pkg.sv
// Shared definitions for the 7-segment display path: active-low segment patterns
// (bit0=a .. bit6=g) and the receive-side converter state encoding.
package seven_segment_to_binary_pkg;

    localparam int SEG_W  = 7;
    localparam int DIGITS = 4;
    localparam int IDX_W  = 2;
    localparam int DIG_W  = 4;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/seven_segment_to_bcd_decoder.sv
// Combinational decode of one active-low 7-segment pattern into a decimal digit.
// Unrecognised patterns yield digit 0 with invalid raised.
module seven_segment_to_bcd_decoder
    import seven_segment_to_binary_pkg::*;
#(
    parameter bit BLANK_IS_ZERO = 1'b1
) (
    input  logic [SEG_W-1:0] segment,
    output logic [DIG_W-1:0] digit,
    output logic             invalid
);

    always_comb begin
        digit   = '0;
        invalid = 1'b0;
        case (segment)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            // A dark digit is a leading-zero suppression unless configured as an error
            SEG_BLANK: invalid = ~BLANK_IS_ZERO;
            default:   invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_segment_to_binary.sv
// Rebuilds the binary value shown on a four-digit 7-segment display, one digit
// per cycle MSD first, with valid/ready handshakes on both sides.
module seven_segment_to_binary
    import seven_segment_to_binary_pkg::*;
#(
    parameter int OUT_W         = 14,
    parameter bit BLANK_IS_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEG_W-1:0] t_segment,
    input  logic [SEG_W-1:0] h_segment,
    input  logic [SEG_W-1:0] d_segment,
    input  logic [SEG_W-1:0] u_segment,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_value,
    output logic             out_err
);

    state_t                        state;
    state_t                        next_state;
    logic [DIGITS-1:0][SEG_W-1:0]  cap_seg;
    logic [IDX_W-1:0]              idx;
    logic [OUT_W-1:0]              acc;
    logic                          err;
    logic [SEG_W-1:0]              sel_seg;
    logic [DIG_W-1:0]              digit;
    logic                          invalid;
    logic [OUT_W-1:0]              acc_next;
    logic                          err_next;
    logic                          accept;
    logic                          last_step;

    function automatic logic [OUT_W-1:0] mul10(input logic [OUT_W-1:0] v);
        return (v << 3) + (v << 1);
    endfunction

    assign in_ready  = rst_n && (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign last_step = (state == CONV) && (idx == IDX_W'(DIGITS - 1));

    // cap_seg[0] holds the thousands digit so the index walks MSD first
    assign sel_seg = cap_seg[idx];

    seven_segment_to_bcd_decoder #(
        .BLANK_IS_ZERO(BLANK_IS_ZERO)
    ) u_decoder (
        .segment (sel_seg),
        .digit   (digit),
        .invalid (invalid)
    );

    assign acc_next = mul10(acc) + OUT_W'(digit);
    assign err_next = err | invalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept)    next_state = CONV;
            CONV: if (last_step) next_state = HOLD;
            HOLD: if (out_ready) next_state = IDLE;
            default:             next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_seg   <= '0;
            idx       <= '0;
            acc       <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_value <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_seg <= {u_segment, d_segment, h_segment, t_segment};
                        idx     <= '0;
                        acc     <= '0;
                        err     <= 1'b0;
                    end
                end
                CONV: begin
                    acc <= acc_next;
                    err <= err_next;
                    idx <= idx + IDX_W'(1);
                    if (last_step) begin
                        out_valid <= 1'b1;
                        // A bad digit poisons the whole reading
                        out_value <= err_next ? '0 : acc_next;
                        out_err   <= err_next;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_value <= '0;
                        out_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_segment_to_binary.sv
// Scoreboard bench for seven_segment_to_binary: two instances (blank as zero / blank
// as error) share stimulus; a reference model fills the queue, a monitor drains it.
module tb_seven_segment_to_binary;

    localparam int OUT_W = 14;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic [6:0]       t_seg = '0;
    logic [6:0]       h_seg = '0;
    logic [6:0]       d_seg = '0;
    logic [6:0]       u_seg = '0;
    logic             in_ready_a, out_valid_a, out_err_a;
    logic             in_ready_b, out_valid_b, out_err_b;
    logic [OUT_W-1:0] out_value_a, out_value_b;

    always #5 clk = ~clk;

    seven_segment_to_binary #(.OUT_W(OUT_W), .BLANK_IS_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .t_segment(t_seg), .h_segment(h_seg), .d_segment(d_seg), .u_segment(u_seg),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_value(out_value_a),
        .out_err(out_err_a)
    );

    seven_segment_to_binary #(.OUT_W(OUT_W), .BLANK_IS_ZERO(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .t_segment(t_seg), .h_segment(h_seg), .d_segment(d_seg), .u_segment(u_seg),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_value(out_value_b),
        .out_err(out_err_b)
    );

    typedef struct {
        int value_a;
        bit err_a;
        int value_b;
        bit err_b;
        int t_acc;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    bit   held = 0;
    bit   idle_chk = 0;
    int   held_val = 0;
    int   held_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic void ref_model(input logic [6:0] t, input logic [6:0] h,
                                      input logic [6:0] d, input logic [6:0] u,
                                      input bit bz, output int v, output bit e);
        logic [6:0] s[4];
        int         w[4];
        int         dg;
        bit         bad;
        s[0] = t; s[1] = h; s[2] = d; s[3] = u;
        w[0] = 1000; w[1] = 100; w[2] = 10; w[3] = 1;
        v = 0;
        e = 0;
        for (int i = 0; i < 4; i++) begin
            dg = 0;
            bad = 1;
            for (int k = 0; k < 10; k++)
                if (s[i] == seg_of(k)) begin
                    dg = k;
                    bad = 0;
                end
            if (s[i] == 7'h7f && bz) bad = 0;
            v += dg * w[i];
            e |= bad;
        end
        if (e) v = 0;
    endfunction

    function automatic logic [6:0] rnd_seg();
        int r;
        r = $urandom_range(0, 19);
        if (r < 16) return seg_of(r % 10);
        else if (r < 18) return 7'h7f;
        else return 7'($urandom);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 0;
            idle_chk = 0;
            chk("reset out_valid", out_valid_a, 0);
            chk("reset out_value", out_value_a, 0);
            chk("reset out_err", out_err_a, 0);
            chk("reset in_ready", in_ready_a, 0);
            chk("reset out_valid nb", out_valid_b, 0);
        end else begin
            if (idle_chk) begin
                chk("idle after xfer out_valid", out_valid_a, 0);
                chk("in_ready after xfer", in_ready_a, 1);
                idle_chk = 0;
            end
            chk("in_ready match nb", in_ready_b, in_ready_a);
            if (out_valid_a || out_valid_b) begin
                chk("out_valid match nb", out_valid_b, out_valid_a);
                chk("in_ready while valid", in_ready_a, 0);
                if (!held) begin
                    if (q.size() == 0) begin
                        chk("unexpected out_valid (queue size)", q.size(), 1);
                    end else begin
                        cur = q[0];
                        chk("latency", cyc, cur.t_acc + 4);
                        chk("out_value", out_value_a, cur.value_a);
                        chk("out_err", out_err_a, int'(cur.err_a));
                        chk("out_value nb", out_value_b, cur.value_b);
                        chk("out_err nb", out_err_b, int'(cur.err_b));
                    end
                    held_val = out_value_a;
                    held_err = out_err_a;
                    held = 1;
                end else begin
                    chk("held out_value stable", out_value_a, held_val);
                    chk("held out_err stable", out_err_a, held_err);
                end
                if (out_ready) begin
                    if (q.size() > 0) void'(q.pop_front());
                    held = 0;
                    idle_chk = 1;
                end
            end
        end
    end

    task automatic send(input logic [6:0] t, input logic [6:0] h,
                        input logic [6:0] d, input logic [6:0] u);
        int   n;
        int   v;
        bit   er;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_a) begin
            chk("in_ready wait timeout", in_ready_a, 1);
            return;
        end
        t_seg = t; h_seg = h; d_seg = d; u_seg = u;
        in_valid = 1'b1;
        ref_model(t, h, d, u, 1'b1, v, er);
        e.value_a = v;
        e.err_a = er;
        ref_model(t, h, d, u, 1'b0, v, er);
        e.value_b = v;
        e.err_b = er;
        e.t_acc = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        t_seg = 7'($urandom); h_seg = 7'($urandom);
        d_seg = 7'($urandom); u_seg = 7'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain queue empty", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d entries pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        send(seg_of(1), seg_of(2), seg_of(3), seg_of(4));
        drain();
        send(seg_of(9), seg_of(9), seg_of(9), seg_of(9));
        send(seg_of(0), seg_of(0), seg_of(0), seg_of(0));
        drain();
        send(7'h7f, 7'h7f, seg_of(4), seg_of(2));
        drain();
        send(seg_of(1), 7'b1010101, seg_of(3), seg_of(4));
        drain();

        // Backpressure: result must sit still and new requests must be refused
        rdy_mode = 2;
        repeat (2) @(negedge clk);
        send(seg_of(8), seg_of(6), seg_of(5), seg_of(1));
        repeat (4) @(negedge clk);
        chk("out_valid under backpressure", out_valid_a, 1);
        t_seg = seg_of(3); h_seg = seg_of(3); d_seg = seg_of(3); u_seg = seg_of(3);
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("still holding after 10 cycles", out_valid_a, 1);
        chk("in_ready low while holding", in_ready_a, 0);
        rdy_mode = 0;
        drain();
        repeat (8) @(negedge clk);

        // Reset in the middle of a conversion discards it completely
        send(seg_of(6), seg_of(6), seg_of(6), seg_of(6));
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready after reset release", in_ready_a, 1);
        chk("out_valid after reset release", out_valid_a, 0);
        send(seg_of(5), seg_of(0), seg_of(0), seg_of(7));
        drain();

        rdy_mode = 1;
        for (int i = 0; i < 40; i++)
            send(rnd_seg(), rnd_seg(), rnd_seg(), rnd_seg());
        rdy_mode = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
